// File: rtl/dmem_pkg.sv
// Shared definitions for the multi-cycle data-memory responder: FSM encoding,
// counter width and default geometry/latency.
package dmem_pkg;
  localparam int CNT_W           = 4;
  localparam int DEPTH_WORDS_DEF = 256;
  localparam int LATENCY_DEF     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/dmem_word_array.sv
// Single-port synchronous word RAM; when enabled the port returns the old
// contents of the addressed word, then applies an optional write on the same edge.
module dmem_word_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic             en_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);
  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      rdata_o <= mem_q[idx_i];
      if (we_i) mem_q[idx_i] <= wdata_i;
    end
  end
endmodule

// File: rtl/data_memory_responder.sv
// MEM-stage data-memory responder: accepts a held load/store request, stalls the
// pipeline for LATENCY busy cycles, then performs the access and pulses ack_o.
module data_memory_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int LATENCY     = LATENCY_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] address_i,
  input  logic        Memory_read_i,
  input  logic        Memory_write_i,
  input  logic [31:0] write_data_i,
  output logic [31:0] read_data_o,
  output logic        stall_o,
  output logic        ack_o
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               wr_q, wr_d;
  logic               rd_q, rd_d;
  logic [31:0]        rdata_hold_q, rdata_hold_d;
  logic [31:0]        ram_rdata;
  logic               ram_en;
  logic               req;
  logic               unused_addr_bits;

  assign req              = Memory_read_i | Memory_write_i;
  assign unused_addr_bits = ^{address_i[31:IDX_W+2], address_i[1:0]};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    wdata_d      = wdata_q;
    wr_d         = wr_q;
    rd_d         = rd_q;
    rdata_hold_d = rdata_hold_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          idx_d   = address_i[IDX_W+1:2];
          wdata_d = write_data_i;
          wr_d    = Memory_write_i;
          rd_d    = Memory_read_i;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DONE: begin
        // Only loads refresh the held result; stores leave it untouched.
        if (rd_q) rdata_hold_d = ram_rdata;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The array is touched only on the final busy edge, and never while reset is
  // asserted, so a store aborted by reset leaves memory unchanged.
  assign ram_en = (state_q == BUSY) && (cnt_q == '0) && !rst_i;

  dmem_word_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk_i  (clk_i),
    .we_i   (wr_q),
    .en_i   (ram_en),
    .idx_i  (idx_q),
    .wdata_i(wdata_q),
    .rdata_o(ram_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      wr_q         <= 1'b0;
      rd_q         <= 1'b0;
      rdata_hold_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      rdata_hold_q <= rdata_hold_d;
    end
  end

  always_ff @(posedge clk_i) begin
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
  end

  assign stall_o     = ((state_q == IDLE) && req) || (state_q == BUSY);
  assign ack_o       = (state_q == DONE);
  assign read_data_o = ((state_q == DONE) && rd_q) ? ram_rdata : rdata_hold_q;
endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: directed scenarios plus randomized traffic
// checked against a word-array reference model.
module tb_data_memory_responder;
  localparam int L     = 4;
  localparam int DEPTH = 256;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] address_i;
  logic        Memory_read_i;
  logic        Memory_write_i;
  logic [31:0] write_data_i;
  logic [31:0] read_data_o;
  logic        stall_o;
  logic        ack_o;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int last_ack_cyc = 0;

  logic [31:0] model [DEPTH];
  logic [31:0] last_rd;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  data_memory_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(L)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .address_i     (address_i),
    .Memory_read_i (Memory_read_i),
    .Memory_write_i(Memory_write_i),
    .write_data_i  (write_data_i),
    .read_data_o   (read_data_o),
    .stall_o       (stall_o),
    .ack_o         (ack_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transaction, starting at a negedge in an IDLE cycle and ending
  // at the negedge of the IDLE cycle after the ack; keep leaves the request held.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit keep, input string tag);
    int          idx;
    logic [31:0] exp_rd;
    idx            = int'((addr >> 2) % DEPTH);
    Memory_read_i  = rd;
    Memory_write_i = wr;
    address_i      = addr;
    write_data_i   = wdata;
    #1 chk({tag, "_stall_accept"}, 32'(stall_o), 32'd1);
    exp_rd = rd ? model[idx] : last_rd;
    for (int c = 1; c <= L; c++) begin
      @(negedge clk_i);
      chk({tag, "_stall_busy"}, 32'(stall_o), 32'd1);
      chk({tag, "_ack_busy"}, 32'(ack_o), 32'd0);
    end
    @(negedge clk_i);
    chk({tag, "_ack_done"}, 32'(ack_o), 32'd1);
    chk({tag, "_stall_done"}, 32'(stall_o), 32'd0);
    chk({tag, "_rdata"}, read_data_o, exp_rd);
    last_ack_cyc = cyc;
    last_rd      = exp_rd;
    if (wr) model[idx] = wdata;
    @(negedge clk_i);
    chk({tag, "_ack_after"}, 32'(ack_o), 32'd0);
    chk({tag, "_rdata_hold"}, read_data_o, last_rd);
    if (!keep) begin
      Memory_read_i  = 1'b0;
      Memory_write_i = 1'b0;
      #1 chk({tag, "_stall_idle"}, 32'(stall_o), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int first_ack;
    logic [31:0] a;
    rst_i = 1'b1; Memory_read_i = 1'b0; Memory_write_i = 1'b0;
    address_i = '0; write_data_i = '0; last_rd = '0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;

    // Reset and idle behaviour
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      chk("idle_stall", 32'(stall_o), 32'd0);
      chk("idle_ack", 32'(ack_o), 32'd0);
      chk("idle_rdata", read_data_o, 32'd0);
    end

    // Basic write then read back
    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, "wr10");
    access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, "rd10");

    // Index wrap and ignored byte offset
    access(1'b0, 1'b1, 32'h400, 32'h11111111, 1'b0, "wr400");
    access(1'b1, 1'b0, 32'h000, 32'h0, 1'b0, "rd000");
    access(1'b1, 1'b0, 32'h013, 32'h0, 1'b0, "rd013");

    // Simultaneous read and write returns the old word
    access(1'b0, 1'b1, 32'h20, 32'hA5A5A5A5, 1'b0, "wr20");
    access(1'b1, 1'b1, 32'h20, 32'h5A5A5A5A, 1'b0, "rw20");
    access(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, "rd20");

    // Reset on the final busy cycle aborts the store
    access(1'b0, 1'b1, 32'h30, 32'h0F0F0F0F, 1'b0, "wr30");
    Memory_write_i = 1'b1; address_i = 32'h30; write_data_i = 32'h12345678;
    for (int c = 1; c <= L; c++) @(negedge clk_i);
    rst_i = 1'b1; Memory_write_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    last_rd = '0;
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_ack", 32'(ack_o), 32'd0);
    chk("rst_rdata", read_data_o, 32'd0);
    @(negedge clk_i);
    chk("rst_ack_next", 32'(ack_o), 32'd0);
    access(1'b1, 1'b0, 32'h30, 32'h0, 1'b0, "rd30");

    // Back-to-back loads with the request held through DONE
    access(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, "b2b_first");
    first_ack = last_ack_cyc;
    access(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, "b2b_second");
    chk("b2b_gap", 32'(last_ack_cyc - first_ack), 32'(L + 2));

    // Randomized traffic over a pre-initialized window
    for (int i = 64; i < 80; i++)
      access(1'b0, 1'b1, 32'(i * 4), $urandom, 1'b0, "init");
    for (int n = 0; n < 40; n++) begin
      int   op;
      logic rd, wr;
      op = int'($urandom_range(0, 2));
      rd = (op != 1);
      wr = (op != 0);
      a  = {$urandom_range(0, 4095) & 32'hFFF, 8'(64 + $urandom_range(0, 15)), 2'($urandom_range(0, 3))} ;
      a  = {a[29:0], 2'b00} | 32'($urandom_range(0, 3));
      access(rd, wr, {$urandom_range(0, 1023) & 32'h3FF, 10'(0), 12'(0)} | 32'((64 + $urandom_range(0, 15)) * 4 + $urandom_range(0, 3)),
             $urandom, bit'($urandom_range(0, 1)), "rand");
    end
    Memory_read_i = 1'b0; Memory_write_i = 1'b0;
    @(negedge clk_i);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
